// File: rtl/n64_rcp_pif_serial_master_if.sv
// Host request bus of the RCP-side PIF serial master: request handshake,
// write-data streaming and read-data return.
`default_nettype none

interface n64_rcp_pif_serial_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_type;
  logic [8:0]  req_addr;
  logic [31:0] wr_data;
  logic        wr_data_req;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        timeout_err;

  // Host side: issues requests and supplies write words
  modport master (
    output req_valid, req_type, req_addr, wr_data,
    input  req_ready, wr_data_req, rd_data, rd_valid, done, timeout_err
  );

  // Serial master side
  modport slave (
    input  req_valid, req_type, req_addr, wr_data,
    output req_ready, wr_data_req, rd_data, rd_valid, done, timeout_err
  );
endinterface

`default_nettype wire

// File: rtl/n64_rcp_pif_serial_master.sv
// RCP-side initiator of the RCP<->PIF single-wire serial link (start bit, 11-bit header, ack, data).
// Optional ack-wait abort enabled by defining PIF_MASTER_ACK_TIMEOUT_EN.
`default_nettype none

module n64_rcp_pif_serial_master #(
  parameter int unsigned ACK_TIMEOUT = 1024
) (
  input  logic                                clk,
  input  logic                                reset_l,
  n64_rcp_pif_serial_master_if.slave          host,
  output logic                                rsp_out,
  input  logic                                pif_in
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_ADDR     = 3'd2,
    S_WAIT_ACK = 3'd3,
    S_RD_DATA  = 3'd4,
    S_WR_ACK   = 3'd5,
    S_WR_DATA  = 3'd6,
    S_DONE     = 3'd7
  } state_t;

  if (ACK_TIMEOUT < 1) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be at least 1");
  end

  state_t      state_q;
  logic        s1_q, s2_q, s3_q;
  logic [1:0]  typ_q;
  logic [4:0]  bit_q;
  logic [3:0]  word_q;
  logic [31:0] shift_q;
  logic        wr_phase_q;
  logic        rsp_q;
  logic        req_ready_q;
  logic        wr_data_req_q;
  logic        rd_valid_q;
  logic        done_q;
  logic        timeout_err_q;
  logic [31:0] rd_data_q;

`ifdef PIF_MASTER_ACK_TIMEOUT_EN
  localparam int unsigned          CNT_W   = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]     TO_LAST = CNT_W'(ACK_TIMEOUT - 1);
  logic [CNT_W-1:0] wait_cnt_q;
`endif

  logic        ack_evt;
  logic        last_word;
  logic [31:0] rd_shift_d;

  always_comb begin
    ack_evt    = ~s2_q & s3_q;
    last_word  = typ_q[0] ? (word_q == 4'd15) : 1'b1;
    rd_shift_d = {shift_q[30:0], s2_q};
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q       <= S_IDLE;
      s1_q          <= 1'b1;
      s2_q          <= 1'b1;
      s3_q          <= 1'b1;
      typ_q         <= 2'd0;
      bit_q         <= 5'd0;
      word_q        <= 4'd0;
      shift_q       <= 32'd0;
      wr_phase_q    <= 1'b0;
      rsp_q         <= 1'b1;
      req_ready_q   <= 1'b0;
      wr_data_req_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      rd_data_q     <= 32'd0;
`ifdef PIF_MASTER_ACK_TIMEOUT_EN
      wait_cnt_q    <= '0;
`endif
    end else begin
      s1_q          <= pif_in;
      s2_q          <= s1_q;
      s3_q          <= s2_q;
      rd_valid_q    <= 1'b0;
      wr_data_req_q <= 1'b0;
      done_q        <= 1'b0;

      case (state_q)
        S_IDLE: begin
          rsp_q <= 1'b1;
          if (host.req_valid && req_ready_q) begin
            // Header rides in the top 11 bits of the shift register
            shift_q       <= {host.req_type, host.req_addr, 21'd0};
            typ_q         <= host.req_type;
            timeout_err_q <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_q         <= 1'b0;
            state_q       <= S_START;
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        S_START: begin
          rsp_q   <= shift_q[31];
          shift_q <= {shift_q[30:0], 1'b0};
          bit_q   <= 5'd0;
          state_q <= S_ADDR;
        end

        S_ADDR: begin
          if (bit_q == 5'd10) begin
            rsp_q   <= 1'b1;
            bit_q   <= 5'd0;
            word_q  <= 4'd0;
            state_q <= S_WAIT_ACK;
`ifdef PIF_MASTER_ACK_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else begin
            rsp_q   <= shift_q[31];
            shift_q <= {shift_q[30:0], 1'b0};
            bit_q   <= bit_q + 5'd1;
          end
        end

        S_WAIT_ACK: begin
          rsp_q <= 1'b1;
          // An ack arriving in the expiry cycle still wins
          if (ack_evt) begin
            wr_phase_q <= 1'b0;
            state_q    <= typ_q[1] ? S_WR_ACK : S_RD_DATA;
          end
`ifdef PIF_MASTER_ACK_TIMEOUT_EN
          else if (wait_cnt_q == TO_LAST) begin
            timeout_err_q <= 1'b1;
            done_q        <= 1'b1;
            req_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
          end
`endif
        end

        S_RD_DATA: begin
          shift_q <= rd_shift_d;
          bit_q   <= bit_q + 5'd1;
          if (bit_q == 5'd31) begin
            rd_data_q  <= rd_shift_d;
            rd_valid_q <= 1'b1;
            word_q     <= word_q + 4'd1;
            if (last_word) begin
              state_q <= S_DONE;
            end
          end
        end

        S_WR_ACK: begin
          if (!wr_phase_q) begin
            wr_phase_q    <= 1'b1;
            rsp_q         <= 1'b0;
            wr_data_req_q <= 1'b1;
          end else begin
            rsp_q   <= host.wr_data[31];
            shift_q <= {host.wr_data[30:0], 1'b0};
            bit_q   <= 5'd0;
            state_q <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          bit_q <= bit_q + 5'd1;
          // Request the next word one cycle early so it is latched on the 32nd bit
          if (bit_q == 5'd30 && !last_word) begin
            wr_data_req_q <= 1'b1;
          end
          if (bit_q == 5'd31) begin
            word_q <= word_q + 4'd1;
            if (last_word) begin
              rsp_q   <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rsp_q   <= host.wr_data[31];
              shift_q <= {host.wr_data[30:0], 1'b0};
            end
          end else begin
            rsp_q   <= shift_q[31];
            shift_q <= {shift_q[30:0], 1'b0};
          end
        end

        S_DONE: begin
          rsp_q       <= 1'b1;
          done_q      <= 1'b1;
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rsp_out          = rsp_q;
  assign host.req_ready   = req_ready_q;
  assign host.wr_data_req = wr_data_req_q;
  assign host.rd_data     = rd_data_q;
  assign host.rd_valid    = rd_valid_q;
  assign host.done        = done_q;
  assign host.timeout_err = timeout_err_q;

endmodule

`default_nettype wire

// File: tb/tb_n64_rcp_pif_serial_master.sv
// Self-checking bench for n64_rcp_pif_serial_master: host driver, PIF responder model and scoreboard.
`default_nettype none

module tb_n64_rcp_pif_serial_master;

  logic clk;
  logic reset_l;
  logic pif_in;
  logic rsp_out;

  n64_rcp_pif_serial_master_if bus();

  n64_rcp_pif_serial_master #(.ACK_TIMEOUT(16)) dut (
    .clk     (clk),
    .reset_l (reset_l),
    .host    (bus),
    .rsp_out (rsp_out),
    .pif_in  (pif_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_src [16];
  logic [31:0] wr_src [16];
  logic [31:0] exp_q [$];
  bit          trace [$];
  logic [31:0] rd_got [$];
  int          rdv_idx [$];
  int          wreq_idx [$];
  int          done_idx;
  bit          te_seen, te_at0, ready_bad;

  function automatic logic [31:0] trace_bits(input int start, input int n);
    logic [31:0] v = '0;
    if (start + n > trace.size()) return 'x;
    for (int i = 0; i < n; i++) v = {v[30:0], trace[start + i]};
    return v;
  endfunction

  // Host + PIF model for one transaction; trace index 0 is the start-bit cycle
  task automatic run_txn(input logic [1:0] typ, input logic [8:0] addr,
                         input int ack_dly, input int abort_at);
    int nw = typ[0] ? 16 : 1;
    int k  = 12 + ack_dly;
    int w  = 0;
    bit pend = 0;
    logic [31:0] wv;
    trace.delete(); rd_got.delete(); rdv_idx.delete(); wreq_idx.delete();
    done_idx = -1; te_seen = 0; te_at0 = 0; ready_bad = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 50) begin @(negedge clk); w++; end
    if (!bus.req_ready) return;
    bus.req_valid = 1'b1; bus.req_type = typ; bus.req_addr = addr; bus.wr_data = wr_src[0];
    @(negedge clk);
    bus.req_valid = 1'b0;
    for (int t = 0; t < k + 32 * nw + 60; t++) begin
      if (t == abort_at) begin reset_l = 1'b0; break; end
      if (pend) begin
        bus.wr_data = wr_src[wreq_idx.size() < 16 ? wreq_idx.size() : 15];
        pend = 0;
      end
      trace.push_back(rsp_out);
      if (t == 0) te_at0 = bus.timeout_err;
      if (bus.rd_valid) begin rd_got.push_back(bus.rd_data); rdv_idx.push_back(t); end
      if (bus.wr_data_req) begin wreq_idx.push_back(t); pend = 1; end
      if (bus.timeout_err) te_seen = 1;
      if (bus.req_ready && !bus.done) ready_bad = 1;
      if (t == k) pif_in = 1'b0;
      else if (!typ[1] && t > k && t <= k + 32 * nw) begin
        wv = rd_src[(t - k - 1) / 32];
        pif_in = wv[31 - ((t - k - 1) % 32)];
      end else pif_in = 1'b1;
      if (bus.done) begin done_idx = t; break; end
      @(negedge clk);
    end
    pif_in = 1'b1;
  endtask

  task automatic test_reset();
    reset_l = 1'b0; pif_in = 1'b1;
    bus.req_valid = 1'b0; bus.req_type = 2'd0; bus.req_addr = 9'd0; bus.wr_data = 32'd0;
    repeat (3) @(negedge clk);
    n_checks++; if (rsp_out !== 1'b1) begin n_fail++; $display("FAIL reset_rsp_out: got %b expected 1", rsp_out); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); end
    n_checks++; if ({bus.rd_valid, bus.done, bus.wr_data_req, bus.timeout_err} !== 4'b0) begin
      n_fail++; $display("FAIL reset_pulses: got %b expected 0000", {bus.rd_valid, bus.done, bus.wr_data_req, bus.timeout_err}); end
    n_checks++; if (bus.rd_data !== 32'd0) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 0", bus.rd_data); end
    reset_l = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_after: got %b expected 1", bus.req_ready); end
  endtask

  task automatic test_read4();
    int k = 15;
    logic [31:0] e, g;
    rd_src[0] = 32'hDEADBEEF; exp_q.push_back(32'hDEADBEEF);
    run_txn(2'd0, 9'h1F0, 3, -1);
    n_checks++; if (trace_bits(0, 12) !== 32'b0001_1111_0000) begin
      n_fail++; $display("FAIL read4_request: got %b expected 000111110000", trace_bits(0, 12)); end
    n_checks++; if (rd_got.size() !== 1) begin n_fail++; $display("FAIL read4_count: got %0d expected 1", rd_got.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = (rd_got.size() > 0) ? rd_got.pop_front() : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL read4_data: got %h expected %h", g, e); end
    end
    n_checks++; if (rdv_idx.size() < 1 || rdv_idx[0] !== k + 35) begin
      n_fail++; $display("FAIL read4_rd_valid_time: got %0d expected %0d", rdv_idx.size() ? rdv_idx[0] : -1, k + 35); end
    n_checks++; if (done_idx !== k + 36) begin n_fail++; $display("FAIL read4_done_time: got %0d expected %0d", done_idx, k + 36); end
    n_checks++; if (ready_bad !== 1'b0) begin n_fail++; $display("FAIL read4_ready_busy: got %b expected 0", ready_bad); end
  endtask

  task automatic test_read64();
    int k = 17;
    logic [31:0] e, g;
    for (int i = 0; i < 16; i++) begin
      rd_src[i] = 32'hC0DE0000 + i * 32'h00011001;
      exp_q.push_back(rd_src[i]);
    end
    run_txn(2'd1, 9'h000, 5, -1);
    n_checks++; if (trace_bits(0, 12) !== 32'b0010_0000_0000) begin
      n_fail++; $display("FAIL read64_request: got %b expected 001000000000", trace_bits(0, 12)); end
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front(); g = (rd_got.size() > 0) ? rd_got.pop_front() : 'x;
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL read64_word%0d: got %h expected %h", i, g, e); end
    end
    n_checks++; if (rdv_idx.size() !== 16 || rdv_idx[15] !== k + 515) begin
      n_fail++; $display("FAIL read64_last_valid: got %0d expected %0d", rdv_idx.size() == 16 ? rdv_idx[15] : -1, k + 515); end
    n_checks++; if (done_idx !== k + 516) begin n_fail++; $display("FAIL read64_done_time: got %0d expected %0d", done_idx, k + 516); end
  endtask

  task automatic test_write4();
    int k = 16;
    logic [31:0] e, g;
    wr_src[0] = 32'h12345678; exp_q.push_back(32'h12345678);
    run_txn(2'd2, 9'h1FF, 4, -1);
    n_checks++; if (trace_bits(0, 12) !== 32'b0101_1111_1111) begin
      n_fail++; $display("FAIL write4_request: got %b expected 010111111111", trace_bits(0, 12)); end
    n_checks++; if (trace_bits(k + 3, 2) !== 32'b10) begin
      n_fail++; $display("FAIL write4_rsp_ack: got %b expected 10", trace_bits(k + 3, 2)); end
    n_checks++; if (wreq_idx.size() !== 1 || wreq_idx[0] !== k + 4) begin
      n_fail++; $display("FAIL write4_wr_data_req: got %0d pulses first at %0d expected 1 at %0d", wreq_idx.size(), wreq_idx.size() ? wreq_idx[0] : -1, k + 4); end
    e = exp_q.pop_front(); g = trace_bits(k + 5, 32);
    n_checks++; if (g !== e) begin n_fail++; $display("FAIL write4_data: got %h expected %h", g, e); end
    n_checks++; if (done_idx !== k + 38 || trace[k + 37] !== 1'b1) begin
      n_fail++; $display("FAIL write4_done: got %0d expected %0d", done_idx, k + 38); end
  endtask

  task automatic test_write64();
    int k = 14;
    logic [31:0] e, g;
    for (int i = 0; i < 16; i++) begin
      wr_src[i] = 32'hA5C30000 | 32'(i);
      exp_q.push_back(wr_src[i]);
    end
    run_txn(2'd3, 9'h0AB, 2, -1);
    for (int i = 0; i < 16; i++) begin
      e = exp_q.pop_front(); g = trace_bits(k + 5 + 32 * i, 32);
      n_checks++; if (g !== e) begin n_fail++; $display("FAIL write64_word%0d: got %h expected %h", i, g, e); end
    end
    n_checks++; if (wreq_idx.size() !== 16 || wreq_idx[15] !== k + 4 + 32 * 15) begin
      n_fail++; $display("FAIL write64_wr_data_req: got %0d pulses expected 16 with last at %0d", wreq_idx.size(), k + 484); end
    n_checks++; if (done_idx !== k + 518) begin n_fail++; $display("FAIL write64_done_time: got %0d expected %0d", done_idx, k + 518); end
  endtask

`ifdef PIF_MASTER_ACK_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] g;
    run_txn(2'd0, 9'h055, 200, -1);
    n_checks++; if (done_idx !== 28) begin n_fail++; $display("FAIL timeout_done_time: got %0d expected 28", done_idx); end
    n_checks++; if (te_seen !== 1'b1 || bus.timeout_err !== 1'b1) begin
      n_fail++; $display("FAIL timeout_err_set: got %b expected 1", bus.timeout_err); end
    n_checks++; if (rd_got.size() !== 0) begin n_fail++; $display("FAIL timeout_no_rd_valid: got %0d expected 0", rd_got.size()); end
    rd_src[0] = 32'h600DCAFE;
    run_txn(2'd0, 9'h055, 3, -1);
    n_checks++; if (te_at0 !== 1'b0) begin n_fail++; $display("FAIL timeout_err_clear: got %b expected 0", te_at0); end
    g = (rd_got.size() > 0) ? rd_got[0] : 'x;
    n_checks++; if (g !== 32'h600DCAFE) begin n_fail++; $display("FAIL timeout_next_read: got %h expected 600dcafe", g); end
  endtask
`else
  task automatic test_no_timeout();
    logic [31:0] g;
    rd_src[0] = 32'h600DCAFE;
    run_txn(2'd0, 9'h055, 1100, -1);
    n_checks++; if (te_seen !== 1'b0) begin n_fail++; $display("FAIL no_timeout_err: got %b expected 0", te_seen); end
    g = (rd_got.size() > 0) ? rd_got[0] : 'x;
    n_checks++; if (g !== 32'h600DCAFE) begin n_fail++; $display("FAIL no_timeout_data: got %h expected 600dcafe", g); end
    n_checks++; if (done_idx !== 1112 + 36) begin n_fail++; $display("FAIL no_timeout_done: got %0d expected %0d", done_idx, 1148); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [31:0] g;
    for (int i = 0; i < 16; i++) rd_src[i] = 32'h11110000 + 32'(i);
    run_txn(2'd1, 9'h000, 2, 187);
    #1;
    n_checks++; if (rsp_out !== 1'b1) begin n_fail++; $display("FAIL midreset_rsp_out: got %b expected 1", rsp_out); end
    n_checks++; if ({bus.rd_valid, bus.done, bus.wr_data_req, bus.req_ready} !== 4'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got %b expected 0000", {bus.rd_valid, bus.done, bus.wr_data_req, bus.req_ready}); end
    n_checks++; if (rd_got.size() !== 5) begin n_fail++; $display("FAIL midreset_words_before: got %0d expected 5", rd_got.size()); end
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b expected 1", bus.req_ready); end
    rd_src[0] = 32'h0BADF00D;
    run_txn(2'd0, 9'h123, 3, -1);
    g = (rd_got.size() > 0) ? rd_got[0] : 'x;
    n_checks++; if (g !== 32'h0BADF00D) begin n_fail++; $display("FAIL midreset_read4: got %h expected 0badf00d", g); end
    n_checks++; if (done_idx !== 15 + 36) begin n_fail++; $display("FAIL midreset_done: got %0d expected 51", done_idx); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read4();
    test_read64();
    test_write4();
    test_write64();
`ifdef PIF_MASTER_ACK_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
